// File: rtl/pipe_hazard_ctrl.sv
// Stall, bubble and flush sequencer for the five-stage pipeline, plus ID-stage operand forwarding selects.
// Resolves load-use, taken-branch, multi-cycle divide and data-memory wait hazards.
module pipe_hazard_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6,
   parameter bit DELAY_SLOT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic       d_usesrs,
   input  logic       d_usesrt,
   input  logic       d_div,
   input  logic       d_branch_taken,
   input  logic [4:0] ern,
   input  logic [4:0] mrn,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic       mwreg,
   input  logic       mm2reg,
   input  logic       mem_req,
   input  logic       mem_ack,
   output logic       pc_en,
   output logic       fd_en,
   output logic       fd_flush,
   output logic       de_en,
   output logic       de_bubble,
   output logic       em_en,
   output logic       mw_bubble,
   output logic [1:0] fwda,
   output logic [1:0] fwdb,
   output logic       busy
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      DIV     = 2'b01,
      MEMWAIT = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   state_t           eff_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;
   logic             ret_div_r;
   logic             ret_div_nx_s;
   logic             memstall_s;
   logic             loaduse_s;
   logic [1:0]       fwda_s;
   logic [1:0]       fwdb_s;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 2);

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] ern_v,
      input logic       ewreg_v,
      input logic       em2reg_v,
      input logic [4:0] mrn_v,
      input logic       mwreg_v,
      input logic       mm2reg_v
   );
      logic [1:0] sel;
      if (ewreg_v && !em2reg_v && (ern_v != 5'd0) && (ern_v == src)) begin
         sel = 2'b01;
      end else if (mwreg_v && !mm2reg_v && (mrn_v != 5'd0) && (mrn_v == src)) begin
         sel = 2'b10;
      end else if (mwreg_v && mm2reg_v && (mrn_v != 5'd0) && (mrn_v == src)) begin
         sel = 2'b11;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection and forwarding decode
   always_comb begin
      memstall_s = mem_req && !mem_ack;
      loaduse_s  = ewreg && em2reg && (ern != 5'd0) &&
                   ((d_usesrs && (ern == d_rs)) || (d_usesrt && (ern == d_rt)));
      fwda_s     = fwd_sel(d_rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
      fwdb_s     = fwd_sel(d_rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
      // Once the wait clears, the state we came from decides this cycle's controls.
      if (state_r == MEMWAIT) begin
         eff_state_s = ret_div_r ? DIV : RUN;
      end else begin
         eff_state_s = state_r;
      end
   end

   // Pipeline control outputs and next-state decode
   always_comb begin
      pc_en        = 1'b1;
      fd_en        = 1'b1;
      de_en        = 1'b1;
      em_en        = 1'b1;
      fd_flush     = 1'b0;
      de_bubble    = 1'b0;
      mw_bubble    = 1'b0;
      fwda         = fwda_s;
      fwdb         = fwdb_s;
      busy         = (state_r != RUN);
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      ret_div_nx_s = ret_div_r;

      if (rst) begin
         pc_en        = 1'b0;
         fd_en        = 1'b0;
         de_bubble    = 1'b1;
         mw_bubble    = 1'b1;
         fwda         = 2'b00;
         fwdb         = 2'b00;
         busy         = 1'b0;
         state_nx_s   = RUN;
         cnt_nx_s     = CNT_ZERO;
         ret_div_nx_s = 1'b0;
      end else if (memstall_s) begin
         pc_en        = 1'b0;
         fd_en        = 1'b0;
         de_en        = 1'b0;
         em_en        = 1'b0;
         mw_bubble    = 1'b1;
         state_nx_s   = MEMWAIT;
         ret_div_nx_s = (state_r == DIV) || ((state_r == MEMWAIT) && ret_div_r);
      end else begin
         ret_div_nx_s = 1'b0;
         case (eff_state_s)
            RUN: begin
               if (d_div) begin
                  pc_en      = 1'b0;
                  fd_en      = 1'b0;
                  de_bubble  = 1'b1;
                  cnt_nx_s   = CNT_START;
                  state_nx_s = DIV;
               end else if (loaduse_s) begin
                  pc_en      = 1'b0;
                  fd_en      = 1'b0;
                  de_bubble  = 1'b1;
                  state_nx_s = RUN;
               end else if (d_branch_taken && (DELAY_SLOT == 1'b0)) begin
                  fd_flush   = 1'b1;
                  state_nx_s = RUN;
               end else begin
                  state_nx_s = RUN;
               end
            end
            DIV: begin
               if (cnt_r != CNT_ZERO) begin
                  pc_en      = 1'b0;
                  fd_en      = 1'b0;
                  de_bubble  = 1'b1;
                  cnt_nx_s   = cnt_r - CNT_ONE;
                  state_nx_s = DIV;
               end else begin
                  state_nx_s = RUN;
               end
            end
            default: begin
               state_nx_s = RUN;
            end
         endcase
      end
   end

   // State, divide counter and return flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= RUN;
         cnt_r     <= CNT_ZERO;
         ret_div_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         ret_div_r <= ret_div_nx_s;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance without delay slot, one with.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] d_rs, d_rt, ern, mrn;
   logic       d_usesrs, d_usesrt, d_div, d_branch_taken;
   logic       ewreg, em2reg, mwreg, mm2reg, mem_req, mem_ack;

   logic       pc_en0, fd_en0, fd_flush0, de_en0, de_bubble0, em_en0, mw_bubble0, busy0;
   logic [1:0] fwda0, fwdb0;
   logic       pc_en1, fd_en1, fd_flush1, de_en1, de_bubble1, em_en1, mw_bubble1, busy1;
   logic [1:0] fwda1, fwdb1;
   logic [7:0] ctl0, ctl1;

   int checks   = 0;
   int failures = 0;

   // ctl = {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_bubble, busy}
   localparam logic [7:0] C_RESET    = 8'b0001_1110;
   localparam logic [7:0] C_NORMAL   = 8'b1101_0100;
   localparam logic [7:0] C_NORM_BSY = 8'b1101_0101;
   localparam logic [7:0] C_STALL    = 8'b0001_1100;
   localparam logic [7:0] C_STALL_B  = 8'b0001_1101;
   localparam logic [7:0] C_FRZ_RUN  = 8'b0000_0010;
   localparam logic [7:0] C_FRZ_BSY  = 8'b0000_0011;
   localparam logic [7:0] C_FLUSH    = 8'b1111_0100;

   assign ctl0 = {pc_en0, fd_en0, fd_flush0, de_en0, de_bubble0, em_en0, mw_bubble0, busy0};
   assign ctl1 = {pc_en1, fd_en1, fd_flush1, de_en1, de_bubble1, em_en1, mw_bubble1, busy1};

   pipe_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(6), .DELAY_SLOT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_usesrs(d_usesrs), .d_usesrt(d_usesrt),
      .d_div(d_div), .d_branch_taken(d_branch_taken), .ern(ern), .mrn(mrn),
      .ewreg(ewreg), .em2reg(em2reg), .mwreg(mwreg), .mm2reg(mm2reg),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en0), .fd_en(fd_en0), .fd_flush(fd_flush0), .de_en(de_en0),
      .de_bubble(de_bubble0), .em_en(em_en0), .mw_bubble(mw_bubble0),
      .fwda(fwda0), .fwdb(fwdb0), .busy(busy0)
   );

   pipe_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(6), .DELAY_SLOT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_usesrs(d_usesrs), .d_usesrt(d_usesrt),
      .d_div(d_div), .d_branch_taken(d_branch_taken), .ern(ern), .mrn(mrn),
      .ewreg(ewreg), .em2reg(em2reg), .mwreg(mwreg), .mm2reg(mm2reg),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en1), .fd_en(fd_en1), .fd_flush(fd_flush1), .de_en(de_en1),
      .de_bubble(de_bubble1), .em_en(em_en1), .mw_bubble(mw_bubble1),
      .fwda(fwda1), .fwdb(fwdb1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d_rs = 5'd0; d_rt = 5'd0; d_usesrs = 1'b0; d_usesrt = 1'b0;
      d_div = 1'b0; d_branch_taken = 1'b0;
      ern = 5'd0; mrn = 5'd0; ewreg = 1'b0; em2reg = 1'b0; mwreg = 1'b0; mm2reg = 1'b0;
      mem_req = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // Reset: outputs forced even with a live forwarding match
      ern = 5'd5; ewreg = 1'b1; d_rs = 5'd5;
      #2 chk("reset_ctl_c0", ctl0, C_RESET);
      chk("reset_fwda", {6'd0, fwda0}, 8'd0);
      cyc(); #2 chk("reset_ctl_c1", ctl0, C_RESET);
      cyc(); rst = 1'b0; idle();
      #2 chk("post_reset_ctl", ctl0, C_NORMAL);

      // Forwarding priority chain on rs
      cyc(); ern = 5'd5; ewreg = 1'b1; em2reg = 1'b0; mrn = 5'd5; mwreg = 1'b1; d_rs = 5'd5;
      #2 chk("fwda_ex", {6'd0, fwda0}, 8'd1);
      chk("fwd_ctl", ctl0, C_NORMAL);
      cyc(); ern = 5'd0;
      #2 chk("fwda_mem_alu", {6'd0, fwda0}, 8'd2);
      cyc(); mm2reg = 1'b1;
      #2 chk("fwda_mem_load", {6'd0, fwda0}, 8'd3);
      cyc(); d_rs = 5'd0;
      #2 chk("fwda_r0", {6'd0, fwda0}, 8'd0);
      // Load in EX is not forwardable; MEM ALU result wins on rt
      cyc(); ern = 5'd5; ewreg = 1'b1; em2reg = 1'b1; mm2reg = 1'b0; d_rt = 5'd5;
      #2 chk("fwdb_skip_ex_load", {6'd0, fwdb0}, 8'd2);

      // Load-use: one bubble, then load data forwarded from MEM
      cyc(); idle(); ern = 5'd3; ewreg = 1'b1; em2reg = 1'b1; d_rt = 5'd3; d_usesrt = 1'b1;
      #2 chk("loaduse_stall", ctl0, C_STALL);
      chk("loaduse_fwdb", {6'd0, fwdb0}, 8'd0);
      cyc(); ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0; mrn = 5'd3; mwreg = 1'b1; mm2reg = 1'b1;
      #2 chk("loaduse_after", ctl0, C_NORMAL);
      chk("loaduse_fwdb11", {6'd0, fwdb0}, 8'd3);

      // Taken branch: flush without delay slot, none with it
      cyc(); idle(); d_branch_taken = 1'b1;
      #2 chk("branch_flush", ctl0, C_FLUSH);
      chk("branch_dslot", ctl1, C_NORMAL);
      cyc(); d_branch_taken = 1'b0;
      #2 chk("branch_after", ctl0, C_NORMAL);
      // Load-use outranks a branch flush
      cyc(); ern = 5'd4; ewreg = 1'b1; em2reg = 1'b1; d_rs = 5'd4; d_usesrs = 1'b1; d_branch_taken = 1'b1;
      #2 chk("loaduse_over_branch", ctl0, C_STALL);

      // Divide: 3 bubbles then release
      cyc(); idle(); d_div = 1'b1;
      #2 chk("div_start", ctl0, C_STALL);
      cyc(); #2 chk("div_bub2", ctl0, C_STALL_B);
      cyc(); #2 chk("div_bub3", ctl0, C_STALL_B);
      cyc(); #2 chk("div_release", ctl0, C_NORM_BSY);
      chk("div_release_dslot", ctl1, C_NORM_BSY);
      cyc(); d_div = 1'b0;
      #2 chk("div_done", ctl0, C_NORMAL);

      // Divide interrupted by a 2-cycle memory wait at cnt=1
      cyc(); d_div = 1'b1;
      #2 chk("divm_start", ctl0, C_STALL);
      cyc(); #2 chk("divm_cnt2", ctl0, C_STALL_B);
      cyc(); mem_req = 1'b1;
      #2 chk("divm_freeze1", ctl0, C_FRZ_BSY);
      cyc(); #2 chk("divm_freeze2", ctl0, C_FRZ_BSY);
      cyc(); mem_ack = 1'b1;
      #2 chk("divm_resume", ctl0, C_STALL_B);
      cyc(); mem_req = 1'b0; mem_ack = 1'b0;
      #2 chk("divm_release", ctl0, C_NORM_BSY);
      cyc(); d_div = 1'b0;
      #2 chk("divm_done", ctl0, C_NORMAL);

      // Same-cycle ack never stalls
      cyc(); mem_req = 1'b1; mem_ack = 1'b1;
      #2 chk("ack_same_cycle", ctl0, C_NORMAL);
      cyc(); mem_req = 1'b0;
      #2 chk("ack_no_wait", ctl0, C_NORMAL);

      // Memory wait from RUN, with ack held high afterwards
      cyc(); mem_req = 1'b1; mem_ack = 1'b0;
      #2 chk("mw_run_enter", ctl0, C_FRZ_RUN);
      cyc(); #2 chk("mw_run_hold", ctl0, C_FRZ_BSY);
      cyc(); mem_ack = 1'b1;
      #2 chk("mw_run_exit", ctl0, C_NORM_BSY);
      cyc(); #2 chk("mw_run_back", ctl0, C_NORMAL);

      // Reset mid-divide abandons it
      cyc(); idle(); d_div = 1'b1;
      cyc(); #2 chk("rdiv_in_div", ctl0, C_STALL_B);
      cyc(); rst = 1'b1;
      #2 chk("rdiv_reset", ctl0, C_RESET);
      cyc(); rst = 1'b0; d_div = 1'b0;
      #2 chk("rdiv_after", ctl0, C_NORMAL);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the 5-stage pipelined CPU. It drives enable, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and generates the ID-stage operand forwarding selects. It resolves four cases: load-use hazards, taken-branch flushes (when no delay slot is used), multi-cycle divide stalls, and data-memory wait states. It sits beside the decode stage, takes its hazard inputs from decode and from the E/M pipeline registers, and is the only source of stall/flush for the pipeline registers.

## Interface
- DIV_CYCLES, 32: total cycles a divide holds in ID (≥2)
- CNT_W, 6: divide counter width; must hold DIV_CYCLES-1
- DELAY_SLOT, 1: 1 = branch delay slot, no flush; 0 = flush IF/ID on taken branch
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- d_rs, d_rt  in  5 each  ID source register numbers
- d_usesrs, d_usesrt  in  1 each  ID instruction reads rs / rt
- d_div  in  1  ID holds a divide instruction
- d_branch_taken  in  1  ID resolved a taken branch/jump
- ern, mrn  in  5 each  EX / MEM destination register
- ewreg, em2reg, mwreg, mm2reg  in  1 each  EX/MEM write-reg and load flags
- mem_req  in  1  MEM stage performs a data-memory access this cycle
- mem_ack  in  1  data memory completes the access this cycle
- pc_en, fd_en  out  1 each  PC / IF-ID write enable
- fd_flush  out  1  IF/ID loads NOP (when fd_en=1)
- de_en  out  1  ID/EX write enable
- de_bubble  out  1  ID/EX loads zero control bits (when de_en=1)
- em_en  out  1  EX/MEM write enable
- mw_bubble  out  1  MEM/WB loads zero control bits
- fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
- busy  out  1  state ≠ RUN

## Operation
- States: RUN, DIV, MEMWAIT. Registers: state, cnt[CNT_W-1:0], ret_div (return-to-DIV flag).
- Forwarding is combinational from the inputs. Per operand X∈{rs,rt}:
  - 01 if ewreg && !em2reg && ern≠0 && ern==X.
  - Else 10 if mwreg && !mm2reg && mrn≠0 && mrn==X.
  - Else 11 if mwreg && mm2reg && mrn≠0 && mrn==X.
  - Else 00.
  - EX has priority over MEM.
- memstall = mem_req && !mem_ack.
- loaduse = ewreg && em2reg && ern≠0 && ((d_usesrs && ern==d_rs) || (d_usesrt && ern==d_rt)).
- Defaults: pc_en=fd_en=de_en=em_en=1; fd_flush=de_bubble=mw_bubble=0.
- Priority: memstall > DIV hold > d_div start > loaduse > branch flush.
- RUN:
  - memstall: pc_en=fd_en=de_en=em_en=0, mw_bubble=1. Go to MEMWAIT, ret_div=0.
  - Else d_div: pc_en=fd_en=0, de_bubble=1. cnt←DIV_CYCLES-2. Go to DIV.
  - Else loaduse: pc_en=fd_en=0, de_bubble=1. Stay in RUN (single-cycle stall; the dependent operand then takes fwd 11).
  - Else d_branch_taken && DELAY_SLOT==0: fd_flush=1.
- DIV: the divide is held in ID.
  - memstall: freeze as in RUN. cnt holds. ret_div=1. Go to MEMWAIT.
  - Else cnt≠0: pc_en=fd_en=0, de_bubble=1, cnt←cnt-1.
  - Else (cnt==0): release. Defaults apply and the divide enters ID/EX. d_div is ignored this cycle. Go to RUN.
- MEMWAIT: freeze outputs while memstall.
  - When mem_ack (memstall=0), outputs revert to the return state's logic in the same cycle.
  - Return state is DIV if ret_div, else RUN. ret_div clears on exit.
- rst=1:
  - Next state RUN, cnt=0, ret_div=0.
  - While rst is high, outputs are forced: pc_en=fd_en=0, de_en=em_en=1, de_bubble=mw_bubble=1, fd_flush=0, fwda=fwdb=00, busy=0.
  - Reset mid-DIV or mid-MEMWAIT abandons the operation.

## Timing
- All outputs are combinational from state and inputs; state updates on the rising clk edge.
- Load-use costs exactly 1 bubble.
- Divide occupies ID for exactly DIV_CYCLES cycles: DIV_CYCLES-1 bubbles, plus 1 release cycle, plus any MEMWAIT cycles.
- mem_ack in the same cycle as mem_req → no stall, never enters MEMWAIT.
- mem_ack may be held high; only memstall matters.
- busy rises the cycle after the entry condition.

## Test plan
- Reset: rst=1 for 2 cycles → pc_en=0, de_bubble=1, mw_bubble=1, busy=0; after release with no hazards → pc_en=fd_en=de_en=em_en=1.
- Forwarding: ern=5, ewreg=1, em2reg=0, mrn=5, mwreg=1, d_rs=5 → fwda=01. Then ern=0 → fwda=10. Then mm2reg=1 → fwda=11. With rs=0 → fwda=00.
- Load-use: ern=3, ewreg=em2reg=1, d_rt=3, d_usesrt=1 → one cycle with pc_en=fd_en=0, de_bubble=1. Next cycle (load in MEM) → no stall, fwdb=11.
- Divide with DIV_CYCLES=4: d_div=1 → 3 bubble cycles, then 1 release cycle with de_en=1, de_bubble=0, busy=1→0.
- Mem stall inside DIV: mem_req=1, mem_ack=0 for 2 cycles at cnt=1 → all enables 0, mw_bubble=1, cnt holds at 1. After ack → DIV resumes; total ID hold = DIV_CYCLES+2.
- Branch: DELAY_SLOT=0, d_branch_taken=1 → fd_flush=1 for 1 cycle. DELAY_SLOT=1 → fd_flush stays 0.
